// File: rtl/muldiv_seq_unit.sv
// muldiv_seq_unit
//   Multi-cycle multiply/divide unit. Radix-2 Booth multiply and restoring
//   divide, one iteration per clock, in signed and unsigned forms. Operand A
//   is the multiplicand/dividend and operand B is the multiplier/divisor.
//   Results are held in hi_out/lo_out until the next operation completes.
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset (clears all state)
//   start        request, sampled only while busy=0
//   op           00 MUL, 01 MULU, 10 DIV, 11 DIVU
//   operand_a    multiplicand / dividend
//   operand_b    multiplier / divisor
//   busy         operation in progress
//   done         one-cycle pulse, results valid
//   hi_out       MUL: product high half; DIV: remainder
//   lo_out       MUL: product low half;  DIV: quotient
//   div_by_zero  DIV/DIVU divisor was zero; held until the next accepted start
module muldiv_seq_unit #(
  parameter int WIDTH     = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  state_t state, state_next;

  logic [1:0]       op_reg;
  logic [WIDTH-1:0] a_reg;      // raw operand A (div-by-zero result, MULU fix-up)
  logic             a_msb_reg;
  logic             b_msb_reg;
  logic [WIDTH:0]   m_reg;      // extended multiplicand, or divisor magnitude
  logic [WIDTH:0]   acc_reg;    // Booth accumulator, or partial remainder
  logic [WIDTH-1:0] q_reg;      // multiplier shifting out, or dividend/quotient
  logic             q_m1_reg;   // Booth q(-1)
  logic [CW-1:0]    cnt_reg;
  logic             short_reg;  // finish after one cycle (zero operand / divisor)

  // ---------------- Input decode at acceptance ----------------
  logic             accept;
  logic             in_signed;
  logic             a_neg_in, b_neg_in;
  logic [WIDTH-1:0] a_mag_in, b_mag_in;
  logic             short_in;

  assign accept    = start && (state != RUN);
  assign in_signed = ~op[0];
  assign a_neg_in  = in_signed & operand_a[WIDTH-1];
  assign b_neg_in  = in_signed & operand_b[WIDTH-1];
  assign a_mag_in  = a_neg_in ? -operand_a : operand_a;
  assign b_mag_in  = b_neg_in ? -operand_b : operand_b;
  assign short_in  = op[1] ? (operand_b == '0)
                           : (EARLY_OUT && ((operand_a == '0) || (operand_b == '0)));

  // ---------------- Iteration datapath ----------------
  logic [WIDTH:0]   mul_sum, div_shift, div_diff, acc_next;
  logic [WIDTH-1:0] div_rem_next, div_q_next, q_next;
  logic [WIDTH-1:0] hi_result, lo_result;
  logic             div_ge, signed_op;

  assign signed_op = ~op_reg[0];

  always_comb begin
    // Booth step: examine (q0, q-1), add/subtract, then arithmetic shift right
    mul_sum = acc_reg;
    case ({q_reg[0], q_m1_reg})
      2'b01:   mul_sum = acc_reg + m_reg;
      2'b10:   mul_sum = acc_reg - m_reg;
      default: mul_sum = acc_reg;
    endcase

    // Restoring step. The remainder is always below the divisor, so the
    // trial difference fits in WIDTH+1 bits and its top bit is the borrow.
    div_shift    = {acc_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    div_diff     = div_shift - m_reg;
    div_ge       = ~div_diff[WIDTH];
    div_rem_next = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_q_next   = {q_reg[WIDTH-2:0], div_ge};

    acc_next  = '0;
    q_next    = '0;
    hi_result = '0;
    lo_result = '0;
    if (op_reg[1]) begin
      acc_next  = {1'b0, div_rem_next};
      q_next    = div_q_next;
      // quotient truncates toward zero, remainder follows the dividend sign
      lo_result = (signed_op & (a_msb_reg ^ b_msb_reg)) ? -div_q_next : div_q_next;
      hi_result = (signed_op & a_msb_reg) ? -div_rem_next : div_rem_next;
    end else begin
      acc_next  = {mul_sum[WIDTH], mul_sum[WIDTH:1]};
      q_next    = {mul_sum[0], q_reg[WIDTH-1:1]};
      lo_result = q_next;
      // WIDTH Booth steps treat the multiplier's top bit as a sign; for MULU
      // a set top bit means the true multiplier is 2^WIDTH larger, so add A
      // back into the high half.
      hi_result = acc_next[WIDTH-1:0] +
                  ((op_reg[0] && b_msb_reg) ? a_reg : {WIDTH{1'b0}});
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = start ? RUN : IDLE;
      RUN:     state_next = (short_reg || (cnt_reg == CW'(1))) ? FINISH : RUN;
      FINISH:  state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == FINISH);
  end

  // ---------------- Datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg      <= '0;
      a_reg       <= '0;
      a_msb_reg   <= 1'b0;
      b_msb_reg   <= 1'b0;
      m_reg       <= '0;
      acc_reg     <= '0;
      q_reg       <= '0;
      q_m1_reg    <= 1'b0;
      cnt_reg     <= '0;
      short_reg   <= 1'b0;
      hi_out      <= '0;
      lo_out      <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      op_reg      <= op;
      a_reg       <= operand_a;
      a_msb_reg   <= operand_a[WIDTH-1];
      b_msb_reg   <= operand_b[WIDTH-1];
      acc_reg     <= '0;
      q_m1_reg    <= 1'b0;
      cnt_reg     <= CW'(WIDTH);
      short_reg   <= short_in;
      div_by_zero <= 1'b0;
      if (op[1]) begin
        m_reg <= {1'b0, b_mag_in};
        q_reg <= a_mag_in;
      end else begin
        m_reg <= {in_signed & operand_a[WIDTH-1], operand_a};
        q_reg <= operand_b;
      end
    end else if (state == RUN) begin
      if (short_reg) begin
        if (op_reg[1]) begin
          div_by_zero <= 1'b1;
          lo_out      <= '1;
          hi_out      <= a_reg;
        end else begin
          hi_out <= '0;
          lo_out <= '0;
        end
      end else begin
        acc_reg  <= acc_next;
        q_reg    <= q_next;
        q_m1_reg <= q_reg[0];
        cnt_reg  <= cnt_reg - CW'(1);
        if (cnt_reg == CW'(1)) begin
          hi_out <= hi_result;
          lo_out <= lo_result;
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq_unit.sv
module tb_muldiv_seq_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, start0;
  logic [1:0]   op;
  logic [W-1:0] operand_a, operand_b;

  logic         busy, done, dbz;
  logic [W-1:0] hi_out, lo_out;
  logic         busy0, done0, dbz0;
  logic [W-1:0] hi0, lo0;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  muldiv_seq_unit #(.WIDTH(W), .EARLY_OUT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .busy(busy), .done(done), .hi_out(hi_out), .lo_out(lo_out),
    .div_by_zero(dbz)
  );

  muldiv_seq_unit #(.WIDTH(W), .EARLY_OUT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .busy(busy0), .done(done0), .hi_out(hi0), .lo_out(lo0),
    .div_by_zero(dbz0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Reference model computed with wide integer arithmetic.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input bit early);
    exp_t e;
    logic [63:0] p;
    longint sa, sbv, r;
    bit sh;
    e.dbz = 1'b0;
    e.hi  = '0;
    e.lo  = '0;
    sh = (o[1] && b == 0) || (early && !o[1] && (a == 0 || b == 0));
    case (o)
      2'd0: begin
        sa = longint'($signed(a)); sbv = longint'($signed(b));
        p = 64'(sa * sbv);
        e.hi = p[63:32]; e.lo = p[31:0];
      end
      2'd1: begin
        p = {32'd0, a} * {32'd0, b};
        e.hi = p[63:32]; e.lo = p[31:0];
      end
      2'd2: begin
        if (b == 0) begin
          e.dbz = 1'b1; e.lo = '1; e.hi = a;
        end else begin
          sa = longint'($signed(a)); sbv = longint'($signed(b));
          r = sa / sbv; p = 64'(r); e.lo = p[31:0];
          r = sa % sbv; p = 64'(r); e.hi = p[31:0];
        end
      end
      default: begin
        if (b == 0) begin
          e.dbz = 1'b1; e.lo = '1; e.hi = a;
        end else begin
          e.lo = a / b; e.hi = a % b;
        end
      end
    endcase
    e.lat = sh ? 1 : W;
    return e;
  endfunction

  // Called just after a negedge; returns just after the negedge where done is
  // seen, so consecutive calls exercise back-to-back acceptance.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit poke, input bit sel);
    exp_t e;
    int lat, bcnt;
    bit got;
    sb.push_back(model(o, a, b, !sel));
    op = o; operand_a = a; operand_b = b;
    if (sel) start0 = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; start0 = 1'b0;
    operand_a = $urandom; operand_b = $urandom; op = 2'($urandom_range(0, 3));
    lat = 0; bcnt = 0; got = 0;
    while (lat < 100) begin
      @(negedge clk);
      if (sel ? done0 : done) begin got = 1; break; end
      if (sel ? busy0 : busy) bcnt++;
      if (poke && lat == 5) begin
        start = 1'b1; op = 2'd1; operand_a = 32'h1234; operand_b = 32'h5678;
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
    if (!got) @(negedge clk);
    e = sb.pop_front();
    $display("txn sel=%0d op=%0d a=%h b=%h hi=%h lo=%h dbz=%0b cycles=%0d",
             sel, o, a, b, sel ? hi0 : hi_out, sel ? lo0 : lo_out,
             sel ? dbz0 : dbz, lat + 1);
    chk("hi_out", sel ? hi0 : hi_out, e.hi);
    chk("lo_out", sel ? lo0 : lo_out, e.lo);
    chk("div_by_zero", sel ? dbz0 : dbz, e.dbz);
    chk("done_cycles", lat + 1, e.lat + 1);
    chk("busy_cycles", bcnt, e.lat);
  endtask

  initial begin
    int ndone;
    rst_n = 1'b0; start = 1'b0; start0 = 1'b0; op = '0;
    operand_a = '0; operand_b = '0;
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_hi", hi_out, 0);
    chk("reset_lo", lo_out, 0);
    chk("reset_dbz", dbz, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // nominal MUL with start pokes during busy
    run_op(2'd0, 32'd7, 32'hFFFFFFFD, 1, 0);
    @(negedge clk); @(negedge clk);
    // back-to-back chain
    run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    run_op(2'd0, 32'h80000000, 32'h80000000, 0, 0);
    run_op(2'd2, 32'hFFFFFFF9, 32'd2, 0, 0);
    run_op(2'd3, 32'hFFFFFFF9, 32'd2, 0, 0);
    run_op(2'd2, 32'd5, 32'd0, 0, 0);
    run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 0, 0);
    run_op(2'd2, 32'd100, 32'hFFFFFFF9, 0, 0);
    run_op(2'd3, 32'd9, 32'd0, 0, 0);
    @(negedge clk);
    run_op(2'd0, 32'd0, 32'd123, 0, 0);
    run_op(2'd1, 32'd123, 32'd0, 0, 0);
    for (int i = 0; i < 6; i++)
      run_op(2'($urandom_range(0, 3)), $urandom, $urandom, 0, 0);

    // EARLY_OUT=0: a nonzero result first, then the zero-operand full run
    @(negedge clk);
    run_op(2'd1, 32'd3, 32'd5, 0, 1);
    run_op(2'd0, 32'd0, 32'd123, 0, 1);

    // reset in the middle of an operation
    @(negedge clk);
    op = 2'd0; operand_a = 32'd7; operand_b = 32'd9; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_hi", hi_out, 0);
    chk("midrst_lo", lo_out, 0);
    chk("midrst_dbz", dbz, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("discarded_after_reset", ndone, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
